c17_bist_ctrl: RTL and testbench

//  Built-in self-test driver for the 5-in/2-out C17 combinational benchmark core (CUT).

---
 rtl/c17_bist_pkg.sv | 25 ++
 rtl/c17_bist_ctrl_if.sv | 24 ++
 rtl/c17_misr.sv | 39 +++
 rtl/c17_bist_ctrl.sv | 99 +++++++++
 tb/tb_c17_bist_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/c17_bist_pkg.sv
// Shared widths, defaults and state encoding for the C17 BIST controller and its MISR.
package c17_bist_pkg;

   localparam int unsigned PAT_W    = 5;
   localparam int unsigned RSP_W    = 2;
   localparam int unsigned SIG_W    = 16;
   localparam int unsigned NUM_PATS = 32;
   localparam int unsigned CNT_W    = $clog2(NUM_PATS + 1);

   // Fibonacci taps for x^5+x^3+1: feedback = cur[4] ^ cur[2]
   localparam logic [PAT_W-1:0] LFSR_TAPS     = 5'b10100;
   localparam logic [PAT_W-1:0] DEF_LFSR_SEED = 5'h01;
   localparam logic [SIG_W-1:0] DEF_MISR_POLY = 16'h1021;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      CHECK = ST_CHECK
   } state_e;

endpackage

// File: rtl/c17_bist_ctrl_if.sv
// Host handshake, status and CUT pattern/response bundle for the C17 BIST controller.
interface c17_bist_ctrl_if;
   import c17_bist_pkg::*;

   logic             start;
   logic [PAT_W-1:0] cut_in;
   logic [RSP_W-1:0] cut_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;
   logic [CNT_W-1:0] pat_count;

   modport slave (
      input  start, cut_out,
      output cut_in, busy, done, pass, signature, pat_count
   );

   modport master (
      output start, cut_out,
      input  cut_in, busy, done, pass, signature, pat_count
   );

endinterface

// File: rtl/c17_misr.sv
// Multiple-input signature register: shift-left Galois MISR absorbing a narrow response word.
module c17_misr #(
   parameter int unsigned      SIG_W = 16,
   parameter int unsigned      RSP_W = 2,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [RSP_W-1:0] data_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (enable) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ {{(SIG_W-RSP_W){1'b0}}, data_in};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST driver for the C17 core: walks all 32 input patterns, compacts responses in a MISR,
// and reports pass/fail against a golden signature through a start/done handshake.
module c17_bist_ctrl
   import c17_bist_pkg::*;
#(
   parameter logic [PAT_W-1:0] LFSR_SEED  = DEF_LFSR_SEED,
   parameter logic [SIG_W-1:0] MISR_POLY  = DEF_MISR_POLY,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
   input logic            clock,
   input logic            reset_n,
   c17_bist_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] cut_in_q, cut_in_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             done_q, done_d;
   logic             misr_clear;
   logic             misr_en;
   logic [SIG_W-1:0] sig;

   assign misr_clear = (state_q == IDLE) && bus.start;
   assign misr_en    = (state_q == RUN);

   always_comb begin
      state_d  = state_q;
      cut_in_d = cut_in_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = RUN;
               cut_in_d = LFSR_SEED;
               cnt_d    = '0;
               pass_d   = 1'b0;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            // Slot 32 is forced to zero (the LFSR never produces it); after slot 32 cut_in parks at zero.
            if (cnt_q >= CNT_W'(NUM_PATS - 2)) begin
               cut_in_d = '0;
            end else begin
               cut_in_d = {cut_in_q[PAT_W-2:0], ^(cut_in_q & LFSR_TAPS)};
            end
            if (cnt_q == CNT_W'(NUM_PATS - 1)) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = IDLE;
            pass_d  = (sig == GOLDEN_SIG);
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cut_in_q <= '0;
         cnt_q    <= '0;
         pass_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cut_in_q <= cut_in_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
         done_q   <= done_d;
      end
   end

   c17_misr #(
      .SIG_W (SIG_W),
      .RSP_W (RSP_W),
      .POLY  (MISR_POLY)
   ) u_misr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (misr_clear),
      .enable  (misr_en),
      .data_in (bus.cut_out),
      .sig     (sig)
   );

   assign bus.cut_in    = cut_in_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.signature = sig;
   assign bus.pat_count = cnt_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench: real C17 netlist as CUT, arithmetic reference model of pattern order and signature.
module tb_c17_bist_ctrl;
   import c17_bist_pkg::*;

   logic clock = 1'b0;
   logic reset_n;
   int   fault_mode = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   // Reference model: plain integer arithmetic over the rules of the block.
   function automatic int pat_after(input int p, input int slot);
      if (slot >= 31) return 0;
      return ((p * 2) % 32) | (((p / 16) ^ (p / 4)) & 1);
   endfunction

   function automatic int misr_step(input int s, input int r);
      int t;
      t = s * 2;
      if (t >= 65536) t = t ^ (65536 + int'(DEF_MISR_POLY));
      return t ^ r;
   endfunction

   function automatic int cut_model(input int p);
      int g1, g2, g3, g6, g7, n11, o22, o23;
      g1  = p & 1;
      g2  = (p / 2) & 1;
      g3  = (p / 4) & 1;
      g6  = (p / 8) & 1;
      g7  = (p / 16) & 1;
      n11 = 1 - (g3 & g6);
      o22 = (g1 & g3) | (g2 & n11);
      o23 = n11 & (g2 | g7);
      return o22 + 2 * o23;
   endfunction

   function automatic int apply_fault(input int r, input int fm);
      if (fm == 1) return r & 2;
      if (fm == 2) return r | 2;
      return r;
   endfunction

   function automatic int model_sig(input int fm);
      int p, s;
      p = int'(DEF_LFSR_SEED);
      s = 0;
      for (int i = 1; i <= 32; i++) begin
         s = misr_step(s, apply_fault(cut_model(p), fm));
         p = pat_after(p, i);
      end
      return s;
   endfunction

   localparam logic [15:0] GOLD = 16'(model_sig(0));

   logic [4:0]  exp_pat [1:32];
   logic [15:0] exp_sig [0:32];

   c17_bist_ctrl_if bus();

   // Real C17 NAND netlist with optional stuck-at on its outputs.
   logic       n10, n11, n16, n19;
   logic [1:0] cut_raw;
   assign n10     = ~(bus.cut_in[0] & bus.cut_in[2]);
   assign n11     = ~(bus.cut_in[2] & bus.cut_in[3]);
   assign n16     = ~(bus.cut_in[1] & n11);
   assign n19     = ~(n11 & bus.cut_in[4]);
   assign cut_raw = {~(n16 & n19), ~(n10 & n16)};
   assign bus.cut_out = (fault_mode == 1) ? {cut_raw[1], 1'b0} :
                        (fault_mode == 2) ? {1'b1, cut_raw[0]} : cut_raw;

   c17_bist_ctrl #(
      .LFSR_SEED  (DEF_LFSR_SEED),
      .MISR_POLY  (DEF_MISR_POLY),
      .GOLDEN_SIG (GOLD)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic build_model(input int fm);
      int p, s;
      p = int'(DEF_LFSR_SEED);
      s = 0;
      exp_sig[0] = '0;
      for (int i = 1; i <= 32; i++) begin
         exp_pat[i] = 5'(p);
         s = misr_step(s, apply_fault(cut_model(p), fm));
         exp_sig[i] = 16'(s);
         p = pat_after(p, i);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cut_in"}, bus.cut_in, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_pass"}, bus.pass, 0);
      check({tag, "_sig"}, bus.signature, 0);
      check({tag, "_cnt"}, bus.pat_count, 0);
   endtask

   // Start a run; optionally pulse a spurious start before RUN edge spur_k and/or during CHECK.
   task automatic do_run(input int fm, input int spur_k, input bit spur_chk);
      logic [31:0] seen;
      fault_mode = fm;
      build_model(fm);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("load_busy", bus.busy, 1);
      check("load_cnt", bus.pat_count, 0);
      check("load_pass", bus.pass, 0);
      check("load_sig", bus.signature, 0);
      check("load_done", bus.done, 0);
      seen = '0;
      for (int k = 1; k <= 32; k++) begin
         check("pat", bus.cut_in, exp_pat[k]);
         seen[bus.cut_in] = 1'b1;
         if (k == spur_k) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         check("cnt", bus.pat_count, k);
         check("sig", bus.signature, exp_sig[k]);
         check("busy", bus.busy, (k < 32));
         check("done_early", bus.done, 0);
      end
      check("exhaustive", seen, 32'hFFFF_FFFF);
      check("pat33", bus.cut_in, 0);
      if (spur_chk) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("done", bus.done, 1);
      check("done_busy", bus.busy, 0);
      check("final_sig", bus.signature, exp_sig[32]);
      check("pass", bus.pass, (exp_sig[32] == GOLD));
      check("cut_idle", bus.cut_in, 0);
   endtask

   task automatic tail();
      tick();
      check("done_pulse", bus.done, 0);
      check("hold_pass", bus.pass, (exp_sig[32] == GOLD));
      check("hold_sig", bus.signature, exp_sig[32]);
      check("idle_busy", bus.busy, 0);
   endtask

   task automatic reset_mid(input int at);
      fault_mode = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < at; k++) tick();
      check("rst_at", bus.pat_count, at);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_zero("rst_mid");
      for (int k = 0; k < 40; k++) begin
         tick();
         check("rst_nodone", bus.done, 0);
         check("rst_busy", bus.busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  fm, sk, gap;
      bit  sc, b2b;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      repeat (3) tick();
      check_zero("por");
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("por_idle_busy", bus.busy, 0);
         check("por_idle_cnt", bus.pat_count, 0);
      end

      do_run(0, 0, 1'b0);
      tail();
      do_run(1, 0, 1'b0);
      tail();
      do_run(0, 11, 1'b1);
      tail();
      reset_mid(17);

      do_run(0, 0, 1'b0);
      do_run(2, 0, 1'b0);
      tail();

      b2b = 1'b0;
      for (int r = 0; r < 8; r++) begin
         fm  = int'($urandom_range(2, 0));
         sk  = int'($urandom_range(32, 2));
         sc  = 1'($urandom_range(1, 0));
         gap = int'($urandom_range(3, 0));
         if (!b2b) repeat (gap) tick();
         do_run(fm, sk, sc);
         b2b = 1'($urandom_range(1, 0));
         if (!b2b) tail();
      end
      if (b2b) tail();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
